exe_muldiv_iter: RTL and testbench
==================================

// Module: exe_muldiv_iter
// PURPOSE
//  Parametrised multi-cycle RV32M execute unit. Runs the 8 M-extension ops
//  (MUL..REMU) iteratively beside the single-cycle exe ALU. Holds the pipeline
//  via stallreq_o to pipe_ctrl while busy. Returns a one-cycle result/valid
//  pulse to the exe_mem writeback mux.
// PARAMETERS
//  XLEN     32  operand/result width (even, >=8)
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk_i        in   1     clock, rising edge
//  rst_i        in   1     synchronous reset, active-high
//  start_i      in   1     INST_TYPE_R_M with funct7=0000001 present in exe
//  flush_i      in   1     jump_enable from pipe_ctrl; abort current op
//  funct3_i     in   3     000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  op1_i        in   XLEN  rs1 value
//  op2_i        in   XLEN  rs2 value
//  reg_waddr_i  in   5     rd
//  result_o     out  XLEN  result, valid only when valid_o=1
//  reg_waddr_o  out  5     rd latched at start
//  valid_o      out  1     one-cycle result strobe
//  busy_o       out  1     state != IDLE
//  stallreq_o   out  1     (IDLE & start_i & ~flush_i) | CALC
// BEHAVIOUR
//  Reset: state=IDLE; result_o=0, reg_waddr_o=0, valid_o=0, busy_o=0; cnt, acc and operand regs=0.
//  FSM IDLE -> CALC -> DONE -> IDLE. Priority: rst_i > flush_i > everything else.
//  IDLE: on start_i & ~flush_i, latch funct3, rd, |op1|, |op2| (signed ops only;
//   MULHSU takes |op1| only), and the result-sign flag; cnt=0; go to CALC.
//  Shortcuts, taken in IDLE directly to DONE, valid_o in cycle 1:
//   DIV/DIVU op2=0 -> quotient all-ones; REM/REMU op2=0 -> remainder=op1.
//   DIV op1=-2^(XLEN-1), op2=-1 -> quotient=op1; REM in the same case -> 0.
//  CALC, mul: radix-2 shift-add into a 2*XLEN accumulator, one bit per cycle.
//  CALC, div: restoring division, one quotient bit per cycle.
//  CALC ends after XLEN iterations (cnt==XLEN-1 -> DONE).
//  DONE: apply sign fix (two's-complement negate when the flag is set).
//   Quotient sign = op1^op2 sign; remainder sign = op1 sign.
//   MUL -> low XLEN of product; MULH/HSU/HU -> high XLEN.
//   valid_o=1 for exactly this cycle; stallreq_o=0 so the pipeline advances;
//   next edge -> IDLE.
//  Latency: start_i in cycle 0 -> valid_o in cycle XLEN+1; stall covers cycles 0..XLEN.
//  start_i while busy_o=1: ignored, never queued.
//  start_i in the DONE cycle: ignored. pipe_ctrl does not present a new
//   instruction until the stall drops.
//  flush_i in CALC/DONE: -> IDLE next edge; valid_o suppressed in that cycle;
//   no writeback.
//  flush_i with start_i in IDLE: start dropped; stallreq_o=0.
//  rst_i mid-operation: all state returns to reset values on that edge.
//  result_o holds its last value outside DONE; consumers gate it with valid_o.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL* ops use a single-cycle combinational
//   2*XLEN multiplier. IDLE -> DONE directly; valid_o in cycle 1; stall only
//   in cycle 0. DIV*/REM* stay iterative.
//  Not defined: every op uses the iterative path, with XLEN+1 latency
//   (shortcuts excepted).
// TESTING
//  1 MUL 7 x -3, XLEN=32 -> valid_o in cycle 33, result 0xFFFFFFEB;
//    stallreq_o high in cycles 0..32.
//  2 MULH/MULHSU/MULHU, op1=0x80000000, op2=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//  4 DIV x/0 -> 0xFFFFFFFF in cycle 1; REMU 5/0 -> 5.
//    DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
//  5 flush_i at cycle 10 of a DIV -> IDLE at cycle 11, no valid_o.
//    Back-to-back start next cycle completes normally. rst_i mid-CALC -> all outputs 0.
//  6 MULDIV_FAST_MUL_EN: MUL 0x10000 x 0x10000 -> valid_o in cycle 1, result 0;
//    MULHU -> 1. DIV latency unchanged (33).

Source files
------------

// File: rtl/exe_muldiv_iter.sv
// -----------------------------------------------------------------------------
// exe_muldiv_iter
//   Multi-cycle RV32M execute unit that sits beside the single-cycle exe ALU.
//   It runs MUL/MULH/MULHSU/MULHU as radix-2 shift-add and DIV/DIVU/REM/REMU
//   as restoring division, one bit per cycle on operand magnitudes.
//   The sign is fixed up when the operation completes.
//   The pipeline is held through stallreq_o while the unit works.
//   The result is presented for exactly one cycle with valid_o.
//
//   Optional feature, selected by macro MULDIV_FAST_MUL_EN:
//     defined   -> MUL* ops use a single-cycle combinational multiplier
//                  (IDLE -> DONE, valid in cycle 1); DIV/REM stay iterative.
//     undefined -> every op is iterative (XLEN+1 cycles, shortcuts excepted).
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   start_i      M-extension instruction present in exe
//   flush_i      pipeline flush; aborts the current op, no writeback
//   funct3_i     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   op1_i/op2_i  rs1 / rs2 values
//   reg_waddr_i  destination register rd
//   result_o     result, meaningful only while valid_o=1
//   reg_waddr_o  rd latched at start
//   valid_o      one-cycle result strobe
//   busy_o       unit not idle
//   stallreq_o   hold request to pipe_ctrl
// -----------------------------------------------------------------------------
module exe_muldiv_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_waddr_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      reg_waddr_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            stallreq_o
);

    localparam int unsigned     AW      = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e           state_q,  state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [4:0]       rd_q,     rd_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [AW-1:0]    acc_q,    acc_d;     // {hi, lo}: product or {remainder, dividend/quotient}
    logic [XLEN-1:0]  opnd_q,   opnd_d;    // multiplicand or divisor magnitude
    logic             neg_q,    neg_d;     // final result must be negated
    logic [XLEN-1:0]  result_q, result_d;

    // ---------------- operand decode (IDLE) ----------------
    logic            op1_signed, op2_signed, s1, s2;
    logic [XLEN-1:0] op1_mag, op2_mag;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] short_res;

    assign op1_signed = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    assign op2_signed = funct3_i inside {3'b000, 3'b001, 3'b100, 3'b110};
    assign s1         = op1_signed & op1_i[XLEN-1];
    assign s2         = op2_signed & op2_i[XLEN-1];
    assign op1_mag    = s1 ? -op1_i : op1_i;
    assign op2_mag    = s2 ? -op2_i : op2_i;

    // Cases with an architecturally fixed answer bypass the iteration.
    assign div_by_zero = funct3_i[2] && (op2_i == '0);
    assign div_ovf     = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                         (op1_i == INT_MIN) && (op2_i == '1);
    assign short_res   = div_by_zero ? (funct3_i[1] ? op1_i : '1)
                                     : (funct3_i[1] ? '0    : op1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [AW-1:0]   fast_a, fast_b, fast_prod;
    logic [XLEN-1:0] fast_res;

    // Extending each operand to 2*XLEN makes one unsigned multiply serve all
    // four signedness combinations (result taken modulo 2^(2*XLEN)).
    assign fast_a    = {{XLEN{s1}}, op1_i};
    assign fast_b    = {{XLEN{s2}}, op2_i};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[AW-1:XLEN];
`endif

    // ---------------- one iteration (CALC) ----------------
    logic [XLEN-1:0] mul_addend, div_rem, div_sel, div_fix, final_res;
    logic [XLEN:0]   mul_sum, div_part;
    logic            div_fits;
    logic [AW-1:0]   mul_next, div_next, acc_step, prod_fix;

    // Multiply: add multiplicand into the high half when the current
    // multiplier bit (acc lsb) is set, then shift the whole accumulator right.
    assign mul_addend = acc_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: partial remainder shifted left with the next dividend
    // bit; the difference fits XLEN bits whenever the divisor fits.
    assign div_part = acc_q[AW-1:XLEN-1];
    assign div_fits = div_part >= {1'b0, opnd_q};
    assign div_rem  = div_part[XLEN-1:0] - opnd_q;
    assign div_next = div_fits ? {div_rem,            acc_q[XLEN-2:0], 1'b1}
                               : {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign acc_step  = funct3_q[2] ? div_next : mul_next;

    // Sign fix-up is computed from the final step so the registered result is
    // ready in the DONE cycle.
    assign prod_fix  = neg_q ? -acc_step : acc_step;
    assign div_sel   = funct3_q[1] ? acc_step[AW-1:XLEN] : acc_step[XLEN-1:0];
    assign div_fix   = neg_q ? -div_sel : div_sel;
    assign final_res = funct3_q[2]               ? div_fix :
                       (funct3_q[1:0] == 2'b00)  ? prod_fix[XLEN-1:0] :
                                                   prod_fix[AW-1:XLEN];

    // ---------------- next state ----------------
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        funct3_d = funct3_i;
                        rd_d     = reg_waddr_i;
                        // Remainder follows the dividend; everything else is op1^op2.
                        neg_d    = (funct3_i == 3'b110) ? s1 : (s1 ^ s2);
                        cnt_d    = '0;
                        if (div_by_zero || div_ovf) begin
                            result_d = short_res;
                            state_d  = S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3_i[2]) begin
                            result_d = fast_res;
                            state_d  = S_DONE;
                        end
`endif
                        else begin
                            state_d = S_CALC;
                            opnd_d  = funct3_i[2] ? op2_mag : op1_mag;
                            acc_d   = {{XLEN{1'b0}}, (funct3_i[2] ? op1_mag : op2_mag)};
                        end
                    end
                end
                S_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // ---------------- outputs ----------------
    assign result_o    = result_q;
    assign reg_waddr_o = rd_q;
    assign valid_o     = (state_q == S_DONE) & ~flush_i;
    assign busy_o      = (state_q != S_IDLE);
    assign stallreq_o  = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_CALC);

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_exe_muldiv_iter
//   Self-checking bench for exe_muldiv_iter. A reference model computes each
//   result with 64-bit integer arithmetic, and the expected cycle timeline
//   (stall/busy/valid) comes from the start cycle, the op latency and any
//   flush cycle. One compare process checks every cycle against that model.
//   Directed cases pin the model to hand-computed literals, then randomized
//   ops follow, including ignored starts, flushes and a mid-op reset.
// -----------------------------------------------------------------------------
module tb_exe_muldiv_iter;

    localparam int XLEN  = 32;
    localparam int NEVER = 1_000_000;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = XLEN + 1;
`endif
    localparam int LAT_DIV = XLEN + 1;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic [4:0]      reg_waddr_i = '0;
    logic [XLEN-1:0] result_o;
    logic [4:0]      reg_waddr_o;
    logic            valid_o;
    logic            busy_o;
    logic            stallreq_o;

    exe_muldiv_iter #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .funct3_i    (funct3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .stallreq_o  (stallreq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Model of the op in flight: start cycle, result cycle, flush cycle.
    bit          op_live = 1'b0;
    int          op_t0 = 0;
    int          op_tend = 0;
    int          op_cut = NEVER;
    logic [31:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    int          seen_valid_cyc = -1;
    bit          run_checks = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = 0;
        up = 0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'h0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic int op_end();
        return (op_cut < op_tend) ? op_cut : op_tend;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every cycle outside reset, against the timeline model.
    always @(negedge clk_i) begin
        if (run_checks && !rst_i) begin
            bit live, ev, eb, es;
            live = op_live && cyc >= op_t0 && cyc <= op_end();
            ev   = live && cyc == op_tend && op_cut != op_tend;
            eb   = live && cyc > op_t0;
            es   = live && cyc < op_tend && !(cyc == op_t0 && op_cut == op_t0);
            check("valid_o", 32'(valid_o), 32'(ev));
            check("busy_o", 32'(busy_o), 32'(eb));
            check("stallreq_o", 32'(stallreq_o), 32'(es));
            if (ev && valid_o) begin
                seen_valid_cyc = cyc;
                check("result_o", result_o, exp_res);
                check("reg_waddr_o", 32'(reg_waddr_o), 32'(exp_rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit flush_too);
        funct3_i       = f;
        op1_i          = a;
        op2_i          = b;
        reg_waddr_i    = rd;
        start_i        = 1'b1;
        flush_i        = flush_too;
        op_t0          = cyc;
        op_tend        = cyc + model_latency(f, a, b);
        op_cut         = flush_too ? cyc : NEVER;
        exp_res        = ref_result(f, a, b);
        exp_rd         = rd;
        op_live        = 1'b1;
        seen_valid_cyc = -1;
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
    endtask

    // Advance past the end of the current op; optionally present starts that
    // must be ignored because the unit is busy or in its DONE cycle.
    task automatic wait_done(input bit spurious);
        while (cyc <= op_end()) begin
            start_i = 1'b0;
            if (spurious && $urandom_range(0, 3) == 0) begin
                start_i     = 1'b1;
                funct3_i    = 3'($urandom);
                op1_i       = $urandom;
                op2_i       = $urandom;
                reg_waddr_i = 5'($urandom);
            end
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] want, input int want_lat);
        check({name, "_model"}, ref_result(f, a, b), want);
        start_op(f, a, b, 5'($urandom_range(1, 31)), 1'b0);
        wait_done(1'b0);
        check({name, "_latency"}, 32'(seen_valid_cyc - op_t0), 32'(want_lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and reset values.
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_result", result_o, 32'h0);
        check("rst_waddr", 32'(reg_waddr_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_stall", 32'(stallreq_o), 32'h0);
        run_checks = 1'b1;

        // Directed cases with hand-computed expectations.
        run_dir("mul_7x-3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
        run_dir("mulh",        3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_MUL);
        run_dir("mulhsu",      3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_MUL);
        run_dir("mulhu",       3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, LAT_MUL);
        run_dir("div_-7/2",    3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, LAT_DIV);
        run_dir("rem_-7/2",    3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, LAT_DIV);
        run_dir("divu_max/2",  3'b101, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF, LAT_DIV);
        run_dir("div_by0",     3'b100, 32'd1234,       32'd0,          32'hFFFF_FFFF, 1);
        run_dir("remu_by0",    3'b111, 32'd5,          32'd0,          32'd5,         1);
        run_dir("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_dir("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        run_dir("mul_2^32",    3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0,         LAT_MUL);
        run_dir("mulhu_2^32",  3'b011, 32'h0001_0000, 32'h0001_0000, 32'h1,         LAT_MUL);

        // Flush at cycle 10 of a DIV, then a back-to-back start.
        start_op(3'b100, 32'd100, 32'd7, 5'd3, 1'b0);
        while (cyc < op_t0 + 10) tick();
        flush_i = 1'b1;
        op_cut  = cyc;
        tick();
        flush_i = 1'b0;
        check("flush_calc_idle", 32'(busy_o), 32'h0);
        check("flush_calc_novalid", 32'(seen_valid_cyc), 32'hFFFF_FFFF);
        start_op(3'b101, 32'd1000, 32'd9, 5'd4, 1'b0);
        wait_done(1'b0);
        check("b2b_latency", 32'(seen_valid_cyc - op_t0), 32'(LAT_DIV));

        // Flush together with start: dropped, no stall.
        start_op(3'b100, 32'd50, 32'd5, 5'd6, 1'b1);
        check("flush_start_idle", 32'(busy_o), 32'h0);

        // Flush in the DONE cycle: strobe suppressed.
        start_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1'b0);
        while (cyc < op_tend) tick();
        flush_i = 1'b1;
        op_cut  = cyc;
        tick();
        flush_i = 1'b0;
        check("flush_done_novalid", 32'(seen_valid_cyc), 32'hFFFF_FFFF);

        // Randomized ops with ignored starts and occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            start_op(3'($urandom), pick(), pick(), 5'($urandom), 1'b0);
            wait_done(1'b1);
            if ($urandom_range(0, 2) == 0) tick();
        end

        // Reset mid-operation after a completed op left nonzero outputs.
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21, 1'b0);
        wait_done(1'b0);
        start_op(3'b100, 32'd1000, 32'd3, 5'd9, 1'b0);
        while (cyc < op_t0 + 5) tick();
        rst_i   = 1'b1;
        op_live = 1'b0;
        tick();
        rst_i = 1'b0;
        check("midrst_result", result_o, 32'h0);
        check("midrst_waddr", 32'(reg_waddr_o), 32'h0);
        check("midrst_valid", 32'(valid_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        check("midrst_stall", 32'(stallreq_o), 32'h0);
        run_dir("post_rst_rem", 3'b110, 32'd17, 32'hFFFF_FFFB, 32'd2, LAT_DIV);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
